spram_rr_arbiter: RTL
=====================

# spram_rr_arbiter

- Shares one single-port 1024x32 RAM (`spram`) between NUM_REQ requesters.
- Uses round-robin arbitration with a valid/ready request handshake and an optional lock for atomic multi-access sequences.
- Returns read data to the winning requester through a one-hot response strobe.
- Sits between the datapath clients (activation/weight fetch engines) and the `spram` instance, and drives the RAM pins directly.

## Interface

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- ADDR_W, 10, RAM address width
- DATA_W, 32, RAM data width

Ports:
- clk  input  1  clock; all logic rising-edge
- reset  input  1  asynchronous, active-low reset
- req_valid  input  NUM_REQ  request pending, one bit per requester
- req_ready  output  NUM_REQ  grant/accept; at most one bit high
- req_wren  input  NUM_REQ  1 = write, 0 = read
- req_lock  input  NUM_REQ  keep grant after this access
- req_addr  input  NUM_REQ*ADDR_W  packed addresses; requester i at [i*ADDR_W +: ADDR_W]
- req_wdata  input  NUM_REQ*DATA_W  packed write data, same packing
- rsp_valid  output  NUM_REQ  one-hot read-data strobe, one cycle wide
- rsp_rdata  output  DATA_W  read data, qualified by rsp_valid
- ram_address  output  ADDR_W  to `spram` address
- ram_wren  output  1  to `spram` wren
- ram_data  output  DATA_W  to `spram` data
- ram_out  input  DATA_W  from `spram` out (1-cycle registered read)

## Operation

- **Handshake:** access i is accepted on a cycle with req_valid[i] && req_ready[i].
  - req_ready is combinational from req_valid, the state and the pointer.
  - req_valid must not depend on req_ready.
  - Once raised, req_valid and its payload stay stable until accepted.
- **Arbitration (state ARB):** grant the first valid requester scanning from rr_ptr upward, modulo NUM_REQ.
  - On acceptance by requester g, rr_ptr becomes (g+1) mod NUM_REQ.
  - If no valid, all req_ready are 0 and rr_ptr holds.
- **Lock:** accepting g with req_lock[g]=1 moves ARB to LOCKED, with owner = g.
  - In LOCKED, only req_ready[owner] may be high; it equals req_valid[owner].
  - Other requesters wait.
  - Accepting owner with req_lock=0 returns to ARB, and rr_ptr becomes owner+1.
  - Owner dropping req_valid does not release the lock.
- **Command stage:** the accepted access is registered into ram_address/ram_wren/ram_data.
  - On idle cycles ram_wren = 0; address and data hold their previous values.
- **Response:** read tags (one-hot of g, reads only) pass through a 2-stage shift register.
  - rsp_valid = stage-2 tag.
  - rsp_rdata = ram_out, passed straight through, with no extra register.
  - Writes produce no response.
  - Requesters cannot back-pressure responses.
- **Reset:**
  - While reset = 0, asynchronously:
    - state = ARB, rr_ptr = 0
    - tag pipeline cleared
    - ram_address = 0, ram_wren = 0, ram_data = 0
  - req_ready and rsp_valid = 0 during reset.
  - Reset mid-operation discards in-flight reads (no rsp_valid) and any lock.

## Timing

- Accept at edge T.
- RAM command is valid in cycle T+1 (captured by `spram` at edge T+2).
- Read data and rsp_valid are valid in cycle T+2.
- Read latency is 2 cycles from acceptance.
- Throughput: one access per cycle sustained. Back-to-back read-then-write to the same address returns the old data.
- Write followed by read of the same address in consecutive accepted cycles returns the new data.
- Grant changes take effect the same cycle req_valid changes; there is no idle bubble between requesters.

## Structure

- Shared package `spram_arb_pkg`:
  - RAM geometry constants: ADDR_W = 10, DATA_W = 32, depth 1024.
  - State encoding: ARB, LOCKED.
  - Read latency constant RD_LAT = 2.
- One sub-module, `rr_grant_picker`: combinational.
  - Inputs: NUM_REQ request vector and pointer.
  - Output: one-hot grant (all 0 if no request).
  - It holds the modulo scan; the top level holds the FSM, pointer, command registers and tag pipeline.

## Test plan

- **Round-robin fairness:** all 4 valid continuously as reads, addrs 0x10..0x13 → grants 0,1,2,3,0,…, one per cycle. Each rsp_valid bit fires 2 cycles after its grant with the preloaded data.
- **Write/read:** req 2 writes 0xDEADBEEF to 0x3FF, then reads 0x3FF on the next cycle → rsp_valid = 4'b0100 and rsp_rdata = 0xDEADBEEF 2 cycles after the read grant. ram_wren is high exactly one cycle.
- **Lock:** req 1 issues 3 locked accesses, then an unlocked one, while reqs 0, 2 and 3 are valid → req_ready stays only on bit 1 for 4 accepts, including through a 2-cycle gap in req 1 valid. The next grant goes to req 2.
- **Idle:** no valid for 5 cycles → req_ready = 0, ram_wren = 0, ram_address holds, rr_ptr unchanged.
- **Mid-flight reset:** reset asserted asynchronously one cycle after a read accept → rsp_valid never fires, all outputs 0 immediately. After release, the first grant goes to requester 0.

Source files
------------

// File: rtl/spram_arb_pkg.sv
// rtl/spram_arb_pkg.sv - shared RAM geometry, FSM encoding and latency for the spram arbiter
package spram_arb_pkg;

    localparam int RAM_DEPTH  = 1024;
    localparam int RAM_ADDR_W = $clog2(RAM_DEPTH);
    localparam int RAM_DATA_W = 32;

    // One command register stage plus the RAM's own registered read.
    localparam int RD_LAT = 2;

    localparam logic [0:0] ST_ARB    = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    // Wrap-around successor of a requester index.
    function automatic int next_idx(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_grant_picker.sv
// rtl/rr_grant_picker.sv - combinational round-robin scan from a start pointer
module rr_grant_picker
    import spram_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
)
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant
);

    int   idx;
    logic found;

    // Walk upward from ptr, wrapping at NUM_REQ; the first pending request wins.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!found && req[idx[PTR_W-1:0]]) begin
                grant[idx[PTR_W-1:0]] = 1'b1;
                found                 = 1'b1;
            end
        end
    end

endmodule

// File: rtl/spram_rr_arbiter.sv
// rtl/spram_rr_arbiter.sv - round-robin arbiter with lock sharing one single-port RAM
module spram_rr_arbiter
    import spram_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = RAM_ADDR_W,
    parameter int DATA_W  = RAM_DATA_W
)
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ-1:0]        req_wren,
    input  logic [NUM_REQ-1:0]        req_lock,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic [ADDR_W-1:0]         ram_address,
    output logic                      ram_wren,
    output logic [DATA_W-1:0]         ram_data,
    input  logic [DATA_W-1:0]         ram_out
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [0:0]         state;
    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   owner;
    logic [NUM_REQ-1:0] grant;
    logic [NUM_REQ-1:0] accept;
    logic               acc_any;
    logic [PTR_W-1:0]   acc_idx;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_wdata;
    logic               sel_wren;
    logic               sel_lock;
    logic [NUM_REQ-1:0] tag_q [RD_LAT];

    rr_grant_picker #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_picker (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (grant)
    );

    // Ready: round-robin grant in ARB, owner-only pass-through while LOCKED, nothing in reset.
    always_comb begin
        req_ready = '0;
        if (reset) begin
            if (state == ST_ARB) begin
                req_ready = grant;
            end else begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (PTR_W'(i) == owner) begin
                        req_ready[i] = req_valid[i];
                    end
                end
            end
        end
    end

    assign accept  = req_valid & req_ready;
    assign acc_any = |accept;

    // Steer the accepted requester's payload; accept is one-hot or zero.
    always_comb begin
        acc_idx   = '0;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_wren  = 1'b0;
        sel_lock  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (accept[i]) begin
                acc_idx   = PTR_W'(i);
                sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
                sel_wdata = req_wdata[i*DATA_W +: DATA_W];
                sel_wren  = req_wren[i];
                sel_lock  = req_lock[i];
            end
        end
    end

    // Arbitration state, round-robin pointer and lock owner advance on every accept.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= ST_ARB;
            rr_ptr <= '0;
            owner  <= '0;
        end else if (acc_any) begin
            rr_ptr <= PTR_W'(next_idx(int'(acc_idx), NUM_REQ));
            owner  <= acc_idx;
            state  <= sel_lock ? ST_LOCKED : ST_ARB;
        end
    end

    // Command stage: register the accepted access onto the RAM pins; idle cycles only drop wren.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ram_address <= '0;
            ram_wren    <= 1'b0;
            ram_data    <= '0;
        end else begin
            ram_wren <= acc_any & sel_wren;
            if (acc_any) begin
                ram_address <= sel_addr;
                ram_data    <= sel_wdata;
            end
        end
    end

    // Read tags ride alongside the command and RAM read so data and strobe line up.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < RD_LAT; s++) begin
                tag_q[s] <= '0;
            end
        end else begin
            tag_q[0] <= accept & ~req_wren;
            for (int s = 1; s < RD_LAT; s++) begin
                tag_q[s] <= tag_q[s-1];
            end
        end
    end

    assign rsp_valid = tag_q[RD_LAT-1];
    assign rsp_rdata = ram_out;

endmodule
